// File: rtl/num_pkg.sv
// Shared definitions for the numbotron program sequencer: opcodes, FSM states
// and instruction field positions.
package num_pkg;

    // Opcode encodings
    localparam logic [1:0] OP_HALT  = 2'b00;
    localparam logic [1:0] OP_INC   = 2'b01;
    localparam logic [1:0] OP_DECJZ = 2'b10;
    localparam logic [1:0] OP_JMP   = 2'b11;

    // Instruction layout: {opcode, reg index, target}
    localparam int unsigned OP_W  = 2;
    localparam int unsigned REG_W = 2;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StHalted
    } state_e;

    // LSB of the register-index field for a given target width
    function automatic int unsigned reg_lsb(input int unsigned pc_w);
        return pc_w;
    endfunction

    // LSB of the opcode field for a given target width
    function automatic int unsigned op_lsb(input int unsigned pc_w);
        return pc_w + REG_W;
    endfunction

endpackage

// File: rtl/num_decode.sv
// Combinational instruction decode: turns the latched instruction word and the
// register zero flags into strobe vectors and branch information.
module num_decode
    import num_pkg::*;
#(
    parameter int unsigned NREG = 4,
    parameter int unsigned PC_W = 4
) (
    input  logic [PC_W+3:0] ir,
    input  logic [NREG-1:0] reg_z,
    output logic [NREG-1:0] inc_vec,
    output logic [NREG-1:0] dec_vec,
    output logic            branch_taken,
    output logic [PC_W-1:0] next_pc,      // destination when branch_taken is set
    output logic            bad_idx,
    output logic            is_halt
);

    localparam int unsigned RegLsb = reg_lsb(PC_W);
    localparam int unsigned OpLsb  = op_lsb(PC_W);

    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] ridx;
    logic [NREG-1:0]  sel_vec;
    logic             z_sel;

    assign op      = ir[OpLsb +: OP_W];
    assign ridx    = ir[RegLsb +: REG_W];
    assign next_pc = ir[PC_W-1:0];

    // One-hot select of the addressed register; empty when the index is out of range
    always_comb begin
        sel_vec = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            sel_vec[i] = (32'(ridx) == i);
        end
    end

    assign z_sel = |(reg_z & sel_vec);

    // Only register-addressing opcodes can carry a bad index
    assign bad_idx = ((op == OP_INC) || (op == OP_DECJZ)) && (32'(ridx) >= NREG);

    // Opcode decode into strobes and branch decision
    always_comb begin
        inc_vec      = '0;
        dec_vec      = '0;
        branch_taken = 1'b0;
        is_halt      = 1'b0;
        unique case (op)
            OP_HALT: begin
                is_halt = 1'b1;
            end
            OP_INC: begin
                if (!bad_idx) begin
                    inc_vec = sel_vec;
                end
            end
            OP_DECJZ: begin
                if (!bad_idx) begin
                    if (z_sel) begin
                        branch_taken = 1'b1;
                    end else begin
                        dec_vec = sel_vec;
                    end
                end
            end
            OP_JMP: begin
                branch_taken = 1'b1;
            end
            default: begin
                is_halt = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/num_sequencer.sv
// Program sequencer for the numbotron counter machine. Fetches from a
// synchronous ROM, decodes, and issues single-cycle inc/dec strobes to the
// register bank. All progress is gated by the slow-clock enable step.
module num_sequencer
    import num_pkg::*;
#(
    parameter int unsigned NREG  = 4,
    parameter int unsigned PC_W  = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             start,
    output logic [PC_W-1:0]  prog_addr,
    input  logic [PC_W+3:0]  prog_data,
    output logic [NREG-1:0]  reg_inc,
    output logic [NREG-1:0]  reg_dec,
    input  logic [NREG-1:0]  reg_z,
    output logic [PC_W-1:0]  pc,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] instr_count
);

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  addr_q, addr_d;
    logic [PC_W+3:0]  ir_q, ir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             halted_q, halted_d;

    logic [NREG-1:0]  inc_vec, dec_vec;
    logic             branch_taken, bad_idx, is_halt;
    logic [PC_W-1:0]  branch_pc;
    logic [PC_W-1:0]  exec_pc;
    logic             in_exec;

    num_decode #(
        .NREG (NREG),
        .PC_W (PC_W)
    ) u_decode (
        .ir           (ir_q),
        .reg_z        (reg_z),
        .inc_vec      (inc_vec),
        .dec_vec      (dec_vec),
        .branch_taken (branch_taken),
        .next_pc      (branch_pc),
        .bad_idx      (bad_idx),
        .is_halt      (is_halt)
    );

    // Address following the current instruction; pc+1 wraps silently
    always_comb begin
        if (branch_taken) begin
            exec_pc = branch_pc;
        end else if (is_halt) begin
            exec_pc = pc_q;
        end else begin
            exec_pc = pc_q + PC_W'(1);
        end
    end

    // Next-state logic; nothing moves unless step is high
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (step) begin
            unique case (state_q)
                StIdle, StHalted: begin
                    if (start) begin
                        state_d = StFetch;
                        pc_d    = '0;
                        addr_d  = '0;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                    end
                end
                StFetch: begin
                    // prog_addr was loaded on entry; this step covers ROM latency
                    state_d = StDecode;
                end
                StDecode: begin
                    ir_d    = prog_data;
                    state_d = StExec;
                end
                StExec: begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                    if (is_halt) begin
                        state_d = StHalted;
                    end else begin
                        state_d = StFetch;
                        pc_d    = exec_pc;
                        addr_d  = exec_pc;
                        if (bad_idx) begin
                            err_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
        busy_d   = (state_d == StFetch) || (state_d == StDecode) || (state_d == StExec);
        halted_d = (state_d == StHalted);
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= '0;
            addr_q   <= '0;
            ir_q     <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            ir_q     <= ir_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

    // Strobes decode from state, so an asynchronous reset drops them at once
    assign in_exec = (state_q == StExec) && step;
    assign reg_inc = in_exec ? inc_vec : '0;
    assign reg_dec = in_exec ? dec_vec : '0;

    assign prog_addr   = addr_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign err         = err_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_num_sequencer.sv
// Directed bench for num_sequencer with a ROM model and a counting register bank.
module tb_num_sequencer;

    localparam int unsigned NREG  = 2;
    localparam int unsigned PC_W  = 4;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             step;
    logic             start;
    logic [PC_W-1:0]  prog_addr;
    logic [PC_W+3:0]  prog_data;
    logic [NREG-1:0]  reg_inc;
    logic [NREG-1:0]  reg_dec;
    logic [NREG-1:0]  reg_z;
    logic [PC_W-1:0]  pc;
    logic             busy;
    logic             halted;
    logic             err;
    logic [CNT_W-1:0] instr_count;

    logic [PC_W+3:0] rom [16];

    int n_checks = 0;
    int n_fail   = 0;

    // Register-bank model state (written only by the monitor processes)
    int inc_cnt [NREG] = '{default: 0};
    int dec_cnt [NREG] = '{default: 0};
    int cyc            = 0;
    int inc0_last      = 0;
    int inc0_gap       = 0;
    int viol           = 0;
    logic [31:0] prev_snap  = '0;
    logic        prev_step  = 1'b0;
    logic        prev_valid = 1'b0;

    // Written only by the stimulus block
    int rv_init [NREG] = '{default: 0};
    int b_inc [NREG];
    int b_dec [NREG];
    int k_step = 0;
    int to;

    num_sequencer #(
        .NREG  (NREG),
        .PC_W  (PC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .step        (step),
        .start       (start),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .reg_inc     (reg_inc),
        .reg_dec     (reg_dec),
        .reg_z       (reg_z),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted),
        .err         (err),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: one clk of latency
    always @(posedge clk) prog_data <= rom[prog_addr];

    // Zero flags update on the clock edge that commits a strobe
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NREG; i++) begin
            reg_z[i] <= ((rv_init[i] + inc_cnt[i] - dec_cnt[i]) == 0);
        end
    end

    // Mid-cycle monitor: count strobes and flag protocol violations
    always @(negedge clk) begin
        logic [31:0] snap;
        snap = {pc, prog_addr, busy, halted, err, 1'b0, instr_count[15:0], 4'b0};
        for (int i = 0; i < NREG; i++) begin
            if (step && reg_inc[i]) inc_cnt[i] <= inc_cnt[i] + 1;
            if (step && reg_dec[i]) dec_cnt[i] <= dec_cnt[i] + 1;
        end
        if (step && reg_inc[0]) begin
            inc0_gap  <= cyc - inc0_last;
            inc0_last <= cyc;
        end
        if (!rst) begin
            viol <= viol
                + (!$onehot0({reg_inc, reg_dec}) ? 1 : 0)
                + (((|{reg_inc, reg_dec}) && !step) ? 1 : 0)
                + ((prev_valid && !prev_step && (snap != prev_snap)) ? 1 : 0);
            prev_snap  <= snap;
            prev_step  <= step;
            prev_valid <= 1'b1;
        end else begin
            prev_valid <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = '0;
    endtask

    task automatic set_reg(input int i, input int v);
        rv_init[i] = v - inc_cnt[i] + dec_cnt[i];
    endtask

    task automatic snap_base();
        for (int i = 0; i < NREG; i++) begin
            b_inc[i] = inc_cnt[i];
            b_dec[i] = dec_cnt[i];
        end
    endtask

    task automatic cycle(input int period);
        @(posedge clk);
        #1;
        k_step++;
        step = (period <= 1) || ((k_step % period) == 0);
    endtask

    // Presents start on a step cycle; returns #1 after the edge that samples it
    task automatic do_start(input int period);
        @(posedge clk);
        #1;
        start = 1'b1;
        step  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        k_step = 0;
        step   = (period <= 1);
    endtask

    task automatic run_until_halt(input int period, input int max_cyc, output int timed_out);
        int n;
        n = 0;
        while (!halted && n < max_cyc) begin
            cycle(period);
            n++;
        end
        timed_out = halted ? 0 : 1;
    endtask

    task automatic load_loop();
        clear_rom();
        rom[0] = 8'h93;  // DECJZ r1 -> 3
        rom[1] = 8'h40;  // INC r0
        rom[2] = 8'hC0;  // JMP 0
        rom[3] = 8'h00;  // HALT
    endtask

    initial begin
        rst   = 1'b1;
        step  = 1'b0;
        start = 1'b0;
        clear_rom();
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_pc", pc, 0);
        check("rst_prog_addr", prog_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_err", err, 0);
        check("rst_count", instr_count, 0);
        check("rst_strobes", {reg_inc, reg_dec}, 0);
        rst  = 1'b0;
        step = 1'b1;

        // Straight-line program {INC r0; INC r0; HALT}
        rom[0] = 8'h40;
        rom[1] = 8'h40;
        rom[2] = 8'h00;
        set_reg(0, 0);
        set_reg(1, 0);
        snap_base();
        do_start(1);
        check("a_busy_after_start", busy, 1);
        repeat (8) cycle(1);
        check("a_not_halted_8", halted, 0);
        cycle(1);
        check("a_halted_9", halted, 1);
        check("a_busy_off", busy, 0);
        check("a_count", instr_count, 3);
        check("a_pc", pc, 2);
        check("a_inc0", inc_cnt[0] - b_inc[0], 2);
        check("a_inc_gap", inc0_gap, 3);

        // Counted loop, step every cycle
        load_loop();
        set_reg(0, 0);
        set_reg(1, 5);
        snap_base();
        do_start(1);
        run_until_halt(1, 500, to);
        check("b_timeout", to, 0);
        check("b_dec1", dec_cnt[1] - b_dec[1], 5);
        check("b_inc0", inc_cnt[0] - b_inc[0], 5);
        check("b_r0", rv_init[0] + inc_cnt[0] - dec_cnt[0], 5);
        check("b_r1", rv_init[1] + inc_cnt[1] - dec_cnt[1], 0);
        check("b_count", instr_count, 17);
        check("b_pc", pc, 3);
        check("b_err", err, 0);

        // Same loop with step one cycle in four
        set_reg(0, 0);
        set_reg(1, 5);
        snap_base();
        do_start(4);
        run_until_halt(4, 2000, to);
        check("c_timeout", to, 0);
        check("c_dec1", dec_cnt[1] - b_dec[1], 5);
        check("c_inc0", inc_cnt[0] - b_inc[0], 5);
        check("c_count", instr_count, 17);
        check("c_pc", pc, 3);
        check("c_violations", viol, 0);
        step = 1'b1;

        // Bad register index (NREG=2, INC r3)
        clear_rom();
        rom[0] = 8'h70;  // INC r3
        rom[1] = 8'h00;  // HALT
        snap_base();
        do_start(1);
        run_until_halt(1, 100, to);
        check("d_timeout", to, 0);
        check("d_err", err, 1);
        check("d_pc", pc, 1);
        check("d_count", instr_count, 2);
        check("d_no_strobe", (inc_cnt[0] - b_inc[0]) + (inc_cnt[1] - b_inc[1])
                             + (dec_cnt[0] - b_dec[0]) + (dec_cnt[1] - b_dec[1]), 0);
        repeat (3) cycle(1);
        check("d_err_sticky", err, 1);

        // PC wrap: 0 DECJZ r0->3; 1 HALT; 3 JMP 15; 15 INC r0
        clear_rom();
        rom[0]  = 8'h83;
        rom[1]  = 8'h00;
        rom[3]  = 8'hCF;
        rom[15] = 8'h40;
        set_reg(0, 0);
        snap_base();
        do_start(1);
        check("e_err_cleared", err, 0);
        repeat (8) cycle(1);
        check("e_pc_15", pc, 15);
        cycle(1);
        check("e_pc_wrap", pc, 0);
        check("e_addr_wrap", prog_addr, 0);
        run_until_halt(1, 100, to);
        check("e_timeout", to, 0);
        check("e_pc", pc, 1);
        check("e_count", instr_count, 5);
        check("e_inc0", inc_cnt[0] - b_inc[0], 1);
        check("e_dec0", dec_cnt[0] - b_dec[0], 1);

        // Reset during EXEC of INC
        clear_rom();
        rom[0] = 8'h40;
        rom[1] = 8'h00;
        set_reg(0, 0);
        snap_base();
        do_start(1);
        cycle(1);
        cycle(1);
        check("f_inc_in_exec", reg_inc, 2'b01);
        #2;
        rst = 1'b1;
        #1;
        check("f_inc_dropped", reg_inc, 0);
        check("f_busy", busy, 0);
        check("f_pc", pc, 0);
        check("f_count", instr_count, 0);
        start = 1'b1;
        cycle(1);
        cycle(1);
        check("f_start_ignored", busy, 0);
        rst = 1'b0;
        cycle(1);
        check("f_restart_busy", busy, 1);
        check("f_restart_pc", pc, 0);
        start = 1'b0;
        run_until_halt(1, 100, to);
        check("f_timeout", to, 0);
        check("f_final_pc", pc, 1);
        check("f_final_count", instr_count, 2);
        check("f_inc0", inc_cnt[0] - b_inc[0], 1);
        check("f_violations", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
